// File: rtl/channel_scheduler.sv
// Issue stage: captures a channel request vector and issues the lowest pending index per
// valid/ready handshake. Define CHANNEL_SCHED_MERGE_EN to merge load_i requests while issuing.
module channel_scheduler #(
  parameter int unsigned SZY = 3,
  parameter int unsigned SZX = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic [SZX-1:0] mask_i,
  output logic [SZY-1:0] idx_o,
  output logic           valid_o,
  input  logic           ready_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [SZX-1:0] pending_o
);

  if (SZX > (1 << SZY)) begin : gen_bad_param
    $error("channel_scheduler: SZX must not exceed 2**SZY");
  end

  typedef enum logic {StIdle, StIssue} state_t;

  state_t         state_q, state_d;
  logic [SZX-1:0] pend_q, pend_d;
  logic [SZY-1:0] idx_q, idx_d;
  logic           done_q, done_d;

  logic           accept;
  logic [SZX-1:0] clr;
  logic [SZX-1:0] p_next;

  function automatic logic [SZY-1:0] lsb_idx(input logic [SZX-1:0] v);
    logic [SZY-1:0] r;
    r = '0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = SZX - 1; i >= 0; i--) begin
      if (v[i]) r = SZY'(i);
    end
    return r;
  endfunction

  always_comb begin
    accept = (state_q == StIssue) && ready_i;
    clr    = '0;
    for (int i = 0; i < SZX; i++) begin
      if (accept && (idx_q == SZY'(i))) clr[i] = 1'b1;
    end
    p_next = pend_q & ~clr;
`ifdef CHANNEL_SCHED_MERGE_EN
    if ((state_q == StIssue) && load_i) p_next = p_next | mask_i;
`endif
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          if (mask_i != '0) begin
            state_d = StIssue;
            pend_d  = mask_i;
            idx_d   = lsb_idx(mask_i);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (p_next == '0) begin
          state_d = StIdle;
          pend_d  = '0;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          pend_d = p_next;
          // The offered index only moves on accept, keeping idx_o stable under backpressure.
          if (accept) idx_d = lsb_idx(p_next);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pend_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign idx_o     = idx_q;
  assign valid_o   = (state_q == StIssue);
  assign busy_o    = (state_q == StIssue);
  assign done_o    = done_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_channel_scheduler.sv
// Self-checking bench for channel_scheduler: table-driven batches with an index scoreboard,
// plus hand-written backpressure, reset, load-while-busy and narrow-width sequences.
module tb_channel_scheduler;

  logic       clk, rst_n;
  logic       load_i, ready_i;
  logic [7:0] mask_i;
  logic [2:0] idx_o;
  logic       valid_o, busy_o, done_o;
  logic [7:0] pending_o;

  logic       load5, ready5;
  logic [4:0] mask5;
  logic [2:0] idx5;
  logic       valid5, busy5, done5;
  logic [4:0] pending5;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  logic [2:0] sb[$];

  channel_scheduler #(.SZY(3), .SZX(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .mask_i(mask_i), .idx_o(idx_o),
    .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o),
    .pending_o(pending_o)
  );

  channel_scheduler #(.SZY(3), .SZX(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .load_i(load5), .mask_i(mask5), .idx_o(idx5),
    .valid_o(valid5), .ready_i(ready5), .busy_o(busy5), .done_o(done5),
    .pending_o(pending5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted index must match the front of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o) valid_cnt++;
      if (done_o) done_cnt++;
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(idx_o), 32'hffff);
        end else begin
          chk("sb_idx", 32'(idx_o), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic push_mask(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) sb.push_back(3'(i));
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (done_cnt != 0) break;
    end
  endtask

  typedef struct {
    logic [7:0] mask;
    int         n_valid;
    logic [2:0] first;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'b1010_0100, 3, 3'd2};
    vecs[1] = '{8'b0000_0011, 2, 3'd0};
    vecs[2] = '{8'h00,        0, 3'd0};
    vecs[3] = '{8'hff,        8, 3'd0};
    vecs[4] = '{8'h80,        1, 3'd7};
    vecs[5] = '{8'h01,        1, 3'd0};
    vecs[6] = '{8'h5a,        4, 3'd1};

    rst_n = 1'b0; load_i = 1'b0; ready_i = 1'b0; mask_i = '0;
    load5 = 1'b0; ready5 = 1'b0; mask5 = '0;
    #12;
    chk("rst_idx", 32'(idx_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_pending", 32'(pending_o), 0);
    chk("rst_valid5", 32'(valid5), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Table-driven batches with ready held high.
    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      load_i = 1'b1; mask_i = vecs[v].mask; ready_i = 1'b1;
      push_mask(vecs[v].mask);
      valid_cnt = 0; done_cnt = 0;
      @(posedge clk); #1 load_i = 1'b0;
      @(negedge clk);
      if (vecs[v].n_valid > 0) begin
        chk("first_valid", 32'(valid_o), 1);
        chk("first_idx", 32'(idx_o), 32'(vecs[v].first));
        chk("first_pending", 32'(pending_o), 32'(vecs[v].mask));
      end else begin
        chk("empty_novalid", 32'(valid_o), 0);
        chk("empty_done", 32'(done_o), 1);
      end
      wait_done(20);
      repeat (2) @(posedge clk);
      chk("tbl_done_once", 32'(done_cnt), 1);
      chk("tbl_valid_cnt", 32'(valid_cnt), 32'(vecs[v].n_valid));
      chk("tbl_busy_after", 32'(busy_o), 0);
      chk("tbl_sb_empty", 32'(sb.size()), 0);
    end

    // Backpressure: offer must hold while ready is low.
    @(posedge clk); #1;
    load_i = 1'b1; mask_i = 8'b0000_0011; ready_i = 1'b0;
    push_mask(8'b0000_0011);
    done_cnt = 0;
    @(posedge clk); #1 load_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(valid_o), 1);
      chk("bp_idx", 32'(idx_o), 0);
    end
    @(posedge clk); #1 ready_i = 1'b1;
    wait_done(10);
    repeat (2) @(posedge clk);
    chk("bp_done_once", 32'(done_cnt), 1);
    chk("bp_sb_empty", 32'(sb.size()), 0);

    // Reset in the middle of a full-mask batch.
    @(posedge clk); #1;
    load_i = 1'b1; mask_i = 8'hff; ready_i = 1'b1;
    push_mask(8'hff);
    @(posedge clk); #1 load_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (idx_o == 3'd5) break;
    end
    chk("mid_idx5_seen", 32'(idx_o), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(valid_o), 0);
    chk("mid_busy", 32'(busy_o), 0);
    chk("mid_pending", 32'(pending_o), 0);
    chk("mid_idx", 32'(idx_o), 0);
    sb.delete();
    done_cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("mid_no_done", 32'(done_cnt), 0);

    // Load while issuing: merged only when the merge feature is built in.
    @(posedge clk); #1;
    load_i = 1'b1; mask_i = 8'b1001_0000; ready_i = 1'b0;
    sb.push_back(3'd4);
`ifdef CHANNEL_SCHED_MERGE_EN
    sb.push_back(3'd1);
`endif
    sb.push_back(3'd7);
    done_cnt = 0;
    @(posedge clk); #1 mask_i = 8'b0000_0010;
    @(posedge clk); #1 begin load_i = 1'b0; ready_i = 1'b1; end
    @(negedge clk);
    chk("lwb_hold_idx", 32'(idx_o), 4);
`ifdef CHANNEL_SCHED_MERGE_EN
    chk("lwb_pending", 32'(pending_o), 32'h92);
`else
    chk("lwb_pending", 32'(pending_o), 32'h90);
`endif
    wait_done(12);
    repeat (2) @(posedge clk);
    chk("lwb_done_once", 32'(done_cnt), 1);
    chk("lwb_sb_empty", 32'(sb.size()), 0);

    // Narrow instance: 5 channels, load on the final accept.
    @(posedge clk); #1;
    load5 = 1'b1; mask5 = 5'b10001; ready5 = 1'b1;
    @(posedge clk); #1 load5 = 1'b0;
    @(negedge clk);
    chk("w5_idx0", 32'(idx5), 0);
    chk("w5_valid0", 32'(valid5), 1);
    @(posedge clk); #1 begin load5 = 1'b1; mask5 = 5'b10000; end
    @(negedge clk);
    chk("w5_idx4", 32'(idx5), 4);
    chk("w5_valid4", 32'(valid5), 1);
    @(posedge clk); #1 load5 = 1'b0;
    @(negedge clk);
`ifdef CHANNEL_SCHED_MERGE_EN
    chk("w5_reissue_valid", 32'(valid5), 1);
    chk("w5_reissue_idx", 32'(idx5), 4);
    chk("w5_reissue_nodone", 32'(done5), 0);
    @(negedge clk);
    chk("w5_final_done", 32'(done5), 1);
    chk("w5_final_valid", 32'(valid5), 0);
`else
    chk("w5_end_valid", 32'(valid5), 0);
    chk("w5_end_done", 32'(done5), 1);
    chk("w5_end_busy", 32'(busy5), 0);
    @(negedge clk);
    chk("w5_done_pulse", 32'(done5), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
